rv32m_unit: RTL and testbench
=============================

Name: rv32m_unit

Overview:
- Iterative RV32M multiply/divide unit used by the execute stage for MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- The execute stage holds START while an M-extension instruction sits in EX.
- The stage stalls while READY is low.
- STALL_M_STD is the pipeline advance enable; a result is consumed when it is high.

Parameters:
- XLEN, 32, operand/result width (only 32 supported).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- STALL_M_STD  in  1  pipeline advance enable; high = EX instruction retires this cycle.
- START  in  1  level request; high while an M instruction is valid in EX; drops on flush.
- M_CNT  in  3  operation (funct3): 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- RS1  in  32  operand rs1 (dividend / multiplicand).
- RS2  in  32  operand rs2 (divisor / multiplier).
- OUT  out  32  result; registered; held stable in DONE.
- READY  out  1  result valid / not busy.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (any time, including mid-operation): state IDLE, OUT=0, iteration counter 0, operand registers 0.
- READY (combinational):
  - IDLE: READY = !START.
  - BUSY: READY = 0.
  - DONE: READY = 1.
- IDLE & START: latch RS1, RS2, M_CNT and go to BUSY. A new op is never latched in BUSY or DONE.
- Multiply (M_CNT[2]=0):
  - One BUSY cycle forms the 64-bit product, registers the selected half into OUT, then DONE.
  - READY is low for exactly 2 cycles: the START cycle plus 1.
  - Signedness: MUL low 32 bits; MULH signed×signed high; MULHSU signed rs1 × unsigned rs2 high; MULHU unsigned×unsigned high.
- Divide (M_CNT[2]=1):
  - Radix-2 restoring division on magnitudes, 32 BUSY iterations, then sign fix-up and OUT register, then DONE.
  - READY is low for 33 cycles.
  - Quotient sign = sign(rs1) XOR sign(rs2) for signed ops; remainder sign = sign(rs1).
- Divide special cases:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give RS1.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
- START falls while BUSY (flush): abort to IDLE next edge; OUT unchanged.
- DONE exit: leave to IDLE on the first edge where STALL_M_STD=1 or START=0.
- DONE hold: with START=1 and STALL_M_STD=0, stay in DONE with READY=1 and OUT held.
- Back-to-back M ops: the next op is latched from IDLE on the cycle after DONE exits. The bubble cycle shows READY=0 because START is high in IDLE.
- OUT is written only on entry to DONE.

Optional Feature:
- Macro RV32M_DIV_FAST_EN.
- Defined: divide-by-zero and signed-overflow cases skip iteration and go to DONE after one BUSY cycle (READY low 2 cycles).
- Not defined: all divides take the full 33-cycle latency, with the special results produced by the fix-up stage.

Decomposition:
- Package rv32m_pkg: M_CNT encoding localparams (MUL..REMU), state enum {IDLE, BUSY, DONE}, XLEN, DIV_ITERS=32.
- One sub-module rv32m_divider: iterative unsigned core with start/valid, magnitude inputs, quotient/remainder outputs.
- Sign handling and the multiplier stay in rv32m_unit.

Test Plan:
- MUL/MULH: RS1=0xFFFFFFFF (-1), RS2=0x00000002, START 1 cycle-aligned.
  - MUL → 0xFFFFFFFE; MULH → 0xFFFFFFFF; MULHU → 0x00000001; MULHSU → 0xFFFFFFFF.
  - READY low exactly 2 cycles each.
- DIV/REM: RS1=-7 (0xFFFFFFF9), RS2=2.
  - DIV → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU → 0x7FFFFFFC; REMU → 1.
  - READY low 33 cycles.
- Special cases:
  - RS2=0, RS1=0x1234: DIV → 0xFFFFFFFF; REMU → 0x1234.
  - 0x80000000 / 0xFFFFFFFF: DIV → 0x80000000; REM → 0.
  - Latency is 2 cycles with RV32M_DIV_FAST_EN and 33 cycles without.
- Stall hold: after DONE, keep START=1 and STALL_M_STD=0 for 5 cycles → READY=1 and OUT stable. Then assert STALL_M_STD → IDLE; the next MUL 3×4 starts and gives 12.
- Flush: START DIVU 100/3, drop START after 10 cycles → back to IDLE, OUT keeps its old value. A new MUL 5×5 gives 25.
- Reset mid-divide: assert RST asynchronously mid-iteration → OUT=0, state IDLE immediately. With START low, READY=1.

Source files
------------

// File: rtl/rv32m_pkg.sv
// Shared types and constants for the rv32m_unit multiply/divide block.
package rv32m_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Two's-complement negate when neg is set; used both for magnitudes and sign fix-up.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/rv32m_if.sv
// Execute-stage request/result bundle between the pipeline and rv32m_unit.
interface rv32m_if;
  import rv32m_pkg::*;

  logic            STALL_M_STD;
  logic            START;
  logic [2:0]      M_CNT;
  logic [XLEN-1:0] RS1;
  logic [XLEN-1:0] RS2;
  logic [XLEN-1:0] OUT;
  logic            READY;

  modport master (
    output STALL_M_STD, START, M_CNT, RS1, RS2,
    input  OUT, READY
  );

  modport slave (
    input  STALL_M_STD, START, M_CNT, RS1, RS2,
    output OUT, READY
  );

endinterface

// File: rtl/rv32m_divider.sv
// Iterative radix-2 restoring divider on unsigned magnitudes.
// quotient/remainder present the result of the current step; valid flags the final step.
module rv32m_divider
  import rv32m_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            valid,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic             busy_r;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN-1:0]  quo_r;
  logic [XLEN-1:0]  rem_r;
  logic [XLEN-1:0]  dvs_r;

  logic [XLEN:0]    r_sh_s;
  logic [XLEN:0]    diff_s;
  logic             qbit_s;
  logic [XLEN-1:0]  quo_nxt_s;
  logic [XLEN-1:0]  rem_nxt_s;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    r_sh_s    = {rem_r, quo_r[XLEN-1]};
    diff_s    = r_sh_s - {1'b0, dvs_r};
    qbit_s    = ~diff_s[XLEN];
    quo_nxt_s = {quo_r[XLEN-2:0], qbit_s};
    if (qbit_s) begin
      rem_nxt_s = diff_s[XLEN-1:0];
    end else begin
      rem_nxt_s = r_sh_s[XLEN-1:0];
    end
  end

  assign valid     = busy_r && (cnt_r == CNT_W'(DIV_ITERS - 1));
  assign quotient  = quo_nxt_s;
  assign remainder = rem_nxt_s;

  // Iteration state; the dividend shifts out of quo_r as quotient bits shift in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      cnt_r  <= '0;
      quo_r  <= '0;
      rem_r  <= '0;
      dvs_r  <= '0;
    end else if (start) begin
      busy_r <= 1'b1;
      cnt_r  <= '0;
      quo_r  <= dividend;
      rem_r  <= '0;
      dvs_r  <= divisor;
    end else if (abort) begin
      busy_r <= 1'b0;
      cnt_r  <= '0;
    end else if (busy_r) begin
      quo_r <= quo_nxt_s;
      rem_r <= rem_nxt_s;
      cnt_r <= cnt_r + CNT_W'(1);
      if (valid) begin
        busy_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rv32m_unit.sv
// RV32M multiply/divide unit: single-step multiply, 32-step divide with sign fix-up.
// Optional macro RV32M_DIV_FAST_EN finishes divide-by-zero / signed overflow in one busy cycle.
module rv32m_unit
  import rv32m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic    CLK,
  input logic    RST,
  rv32m_if.slave m
);

`ifdef RV32M_DIV_FAST_EN
  localparam bit FAST_DIV = 1'b1;
`else
  localparam bit FAST_DIV = 1'b0;
`endif

  state_e          state_r;
  state_e          state_s;
  logic [2:0]      op_r;
  logic [XLEN-1:0] rs1_r;
  logic [XLEN-1:0] rs2_r;

  logic            load_s;
  logic            load_div_s;
  logic            abort_s;
  logic            out_we_s;
  logic [XLEN-1:0] out_d_s;
  logic            ready_s;

  logic            in_signed_s;
  logic [XLEN-1:0] dvd_mag_s;
  logic [XLEN-1:0] dvs_mag_s;
  logic            div_valid_s;
  logic [XLEN-1:0] div_q_s;
  logic [XLEN-1:0] div_r_s;

  logic              a_sx_s;
  logic              b_sx_s;
  logic [2*XLEN-1:0] mul_a_s;
  logic [2*XLEN-1:0] mul_b_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   mul_res_s;

  logic            div_signed_s;
  logic            rs1_neg_s;
  logic            rs2_neg_s;
  logic            div_zero_s;
  logic            div_ovf_s;
  logic            div_special_s;
  logic [XLEN-1:0] quo_fix_s;
  logic [XLEN-1:0] rem_fix_s;
  logic [XLEN-1:0] div_res_s;

  // Divider is loaded from the live operands on the same edge that latches them.
  always_comb begin
    in_signed_s = ~m.M_CNT[0];
    dvd_mag_s   = cond_neg(m.RS1, in_signed_s & m.RS1[XLEN-1]);
    dvs_mag_s   = cond_neg(m.RS2, in_signed_s & m.RS2[XLEN-1]);
    load_div_s  = load_s & m.M_CNT[2];
  end

  rv32m_divider u_divider (
    .clk       (CLK),
    .rst       (RST),
    .start     (load_div_s),
    .abort     (abort_s),
    .dividend  (dvd_mag_s),
    .divisor   (dvs_mag_s),
    .valid     (div_valid_s),
    .quotient  (div_q_s),
    .remainder (div_r_s)
  );

  // Sign-extending to 2*XLEN makes the low half of one product correct for every signedness.
  always_comb begin
    a_sx_s  = ((op_r == MULH) || (op_r == MULHSU)) ? rs1_r[XLEN-1] : 1'b0;
    b_sx_s  = (op_r == MULH) ? rs2_r[XLEN-1] : 1'b0;
    mul_a_s = {{XLEN{a_sx_s}}, rs1_r};
    mul_b_s = {{XLEN{b_sx_s}}, rs2_r};
    prod_s  = mul_a_s * mul_b_s;
    if (op_r == MUL) begin
      mul_res_s = prod_s[XLEN-1:0];
    end else begin
      mul_res_s = prod_s[2*XLEN-1:XLEN];
    end
  end

  // Divide sign fix-up and the architecturally defined special results.
  always_comb begin
    div_signed_s  = ~op_r[0];
    rs1_neg_s     = div_signed_s & rs1_r[XLEN-1];
    rs2_neg_s     = div_signed_s & rs2_r[XLEN-1];
    div_zero_s    = (rs2_r == {XLEN{1'b0}});
    div_ovf_s     = div_signed_s && (rs1_r == {1'b1, {(XLEN-1){1'b0}}})
                                 && (rs2_r == {XLEN{1'b1}});
    div_special_s = div_zero_s | div_ovf_s;
    if (div_zero_s) begin
      quo_fix_s = {XLEN{1'b1}};
      rem_fix_s = rs1_r;
    end else if (div_ovf_s) begin
      quo_fix_s = {1'b1, {(XLEN-1){1'b0}}};
      rem_fix_s = {XLEN{1'b0}};
    end else begin
      quo_fix_s = cond_neg(div_q_s, rs1_neg_s ^ rs2_neg_s);
      rem_fix_s = cond_neg(div_r_s, rs1_neg_s);
    end
    if (op_r[1]) begin
      div_res_s = rem_fix_s;
    end else begin
      div_res_s = quo_fix_s;
    end
  end

  // Next-state, handshake and result-write decode.
  always_comb begin
    state_s  = state_r;
    load_s   = 1'b0;
    abort_s  = 1'b0;
    out_we_s = 1'b0;
    out_d_s  = mul_res_s;
    ready_s  = 1'b0;
    case (state_r)
      IDLE: begin
        ready_s = ~m.START;
        if (m.START) begin
          load_s  = 1'b1;
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        ready_s = 1'b0;
        if (!m.START) begin
          abort_s = 1'b1;
          state_s = IDLE;
        end else if (!op_r[2]) begin
          out_we_s = 1'b1;
          out_d_s  = mul_res_s;
          state_s  = DONE;
        end else if (FAST_DIV && div_special_s) begin
          abort_s  = 1'b1;
          out_we_s = 1'b1;
          out_d_s  = div_res_s;
          state_s  = DONE;
        end else if (div_valid_s) begin
          out_we_s = 1'b1;
          out_d_s  = div_res_s;
          state_s  = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        ready_s = 1'b1;
        if (m.STALL_M_STD || !m.START) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        ready_s = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  assign m.READY = ready_s;

  // State, latched operands and the result register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      op_r    <= 3'b000;
      rs1_r   <= '0;
      rs2_r   <= '0;
      m.OUT   <= '0;
    end else begin
      state_r <= state_s;
      if (load_s) begin
        op_r  <= m.M_CNT;
        rs1_r <= m.RS1;
        rs2_r <= m.RS2;
      end
      if (out_we_s) begin
        m.OUT <= out_d_s;
      end
    end
  end

endmodule

// File: tb/tb_rv32m_unit.sv
// Self-checking bench for rv32m_unit: vector table plus handshake corner sequences.
module tb_rv32m_unit;
  import rv32m_pkg::*;

`ifdef RV32M_DIV_FAST_EN
  localparam int SPEC_LAT = 2;
`else
  localparam int SPEC_LAT = 33;
`endif
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 33;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expv;
    int          lat;
  } vec_t;

  logic        clk;
  logic        rst;
  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          checks;
  int          failures;

  rv32m_if bus();

  rv32m_unit dut (
    .CLK (clk),
    .RST (rst),
    .m   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] expv, input int lat);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.expv = expv; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.M_CNT       = op;
    bus.RS1         = a;
    bus.RS2         = b;
    bus.START       = 1'b1;
    bus.STALL_M_STD = 1'b0;
  endtask

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv);
    exp_q.push_back(expv);
    drive_op(op, a, b);
  endtask

  // Count READY-low cycles from the request, then pop the scoreboard against OUT.
  task automatic wait_done(input string name, input int exp_lat);
    int          lat;
    logic [31:0] e;
    lat = 0;
    #1;
    while (bus.READY !== 1'b1 && lat < 200) begin
      lat++;
      @(posedge clk);
      #2;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
    check({name, " out"}, bus.OUT, e);
  endtask

  task automatic release_op();
    bus.STALL_M_STD = 1'b1;
    bus.START       = 1'b0;
    tick();
    bus.STALL_M_STD = 1'b0;
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst             = 1'b1;
    bus.START       = 1'b0;
    bus.STALL_M_STD = 1'b0;
    bus.M_CNT       = 3'b000;
    bus.RS1         = 32'h0;
    bus.RS2         = 32'h0;

    add("mul -1*2",      MUL,    32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, MUL_LAT);
    add("mulh -1*2",     MULH,   32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT);
    add("mulhu -1*2",    MULHU,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, MUL_LAT);
    add("mulhsu -1*2",   MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT);
    add("mulh min*min",  MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
    add("mulhu min*min", MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
    add("mulhsu min*min",MULHSU, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, MUL_LAT);
    add("div -7/2",      DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT);
    add("rem -7/2",      REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT);
    add("divu -7/2",     DIVU,   32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, DIV_LAT);
    add("remu -7/2",     REMU,   32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, DIV_LAT);
    add("div 100/-3",    DIV,    32'h0000_0064, 32'hFFFF_FFFD, 32'hFFFF_FFDF, DIV_LAT);
    add("rem 100/-3",    REM,    32'h0000_0064, 32'hFFFF_FFFD, 32'h0000_0001, DIV_LAT);
    add("div -100/-3",   DIV,    32'hFFFF_FF9C, 32'hFFFF_FFFD, 32'h0000_0021, DIV_LAT);
    add("rem -100/-3",   REM,    32'hFFFF_FF9C, 32'hFFFF_FFFD, 32'hFFFF_FFFF, DIV_LAT);
    add("divu max/1",    DIVU,   32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, DIV_LAT);
    add("div x/0",       DIV,    32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, SPEC_LAT);
    add("divu x/0",      DIVU,   32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, SPEC_LAT);
    add("rem -7/0",      REM,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, SPEC_LAT);
    add("remu x/0",      REMU,   32'h0000_1234, 32'h0000_0000, 32'h0000_1234, SPEC_LAT);
    add("div ovf",       DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT);
    add("rem ovf",       REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPEC_LAT);
    add("divu min/max",  DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, DIV_LAT);
    add("remu min/max",  REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_LAT);

    tick();
    tick();
    check("reset out", bus.OUT, 32'h0);
    check("reset ready", 32'(bus.READY), 32'h1);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expv);
      wait_done(vecs[i].name, vecs[i].lat);
      release_op();
      check({vecs[i].name, " idle ready"}, 32'(bus.READY), 32'h1);
    end

    // Stall hold in DONE, then back-to-back MUL with the bubble cycle.
    start_op(MUL, 32'd7, 32'd6, 32'd42);
    wait_done("hold mul", MUL_LAT);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #2;
      check("hold ready", 32'(bus.READY), 32'h1);
      check("hold out", bus.OUT, 32'd42);
    end
    bus.STALL_M_STD = 1'b1;
    bus.M_CNT       = MUL;
    bus.RS1         = 32'd3;
    bus.RS2         = 32'd4;
    exp_q.push_back(32'd12);
    @(posedge clk);
    #1;
    bus.STALL_M_STD = 1'b0;
    #1;
    check("bubble ready", 32'(bus.READY), 32'h0);
    wait_done("b2b mul", MUL_LAT);
    release_op();

    // Flush a divide part-way through.
    drive_op(DIVU, 32'd100, 32'd3);
    repeat (10) tick();
    check("flush busy ready", 32'(bus.READY), 32'h0);
    bus.START = 1'b0;
    tick();
    check("flush idle ready", 32'(bus.READY), 32'h1);
    check("flush out hold", bus.OUT, 32'd12);
    tick();
    check("flush out hold2", bus.OUT, 32'd12);
    start_op(MUL, 32'd5, 32'd5, 32'd25);
    wait_done("post-flush mul", MUL_LAT);
    release_op();

    // Asynchronous reset mid-divide.
    drive_op(DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (5) tick();
    rst       = 1'b1;
    bus.START = 1'b0;
    #1;
    check("async reset out", bus.OUT, 32'h0);
    check("async reset ready", 32'(bus.READY), 32'h1);
    tick();
    rst = 1'b0;
    tick();
    start_op(MUL, 32'd3, 32'd4, 32'd12);
    wait_done("post-reset mul", MUL_LAT);
    release_op();
    start_op(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    wait_done("post-reset div", DIV_LAT);
    release_op();

    check("scoreboard empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
